// File: rtl/priority_encoder_16to4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_16to4_pkg
// Description : Shared widths, reset constants, policy codes and helpers for
//               the 16-to-4 sequential request encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package priority_encoder_16to4_pkg;

    localparam int ENC_W = 16;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_RST = 4'hF;

    localparam int POL_FIXED = 0;
    localparam int POL_RR    = 1;

    // Output-register state is exactly ENC_VALID.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } enc_state_t;

    function automatic logic [IDX_W:0] popcount(input logic [ENC_W-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < ENC_W; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_pick_16.sv
`default_nettype none
// ============================================================================
// Module      : priority_pick_16
// Description : Combinational wrap-around search: first set bit at or above
//               i_start, continuing from bit 0 after bit 15.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_pick_16
    import priority_encoder_16to4_pkg::*;
(
    input  logic [ENC_W-1:0] i_vec,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [IDX_W-1:0] w_pos;

    // Walk offsets from the far end so the smallest offset is written last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = '0;
        for (int i = ENC_W - 1; i >= 0; i--) begin
            w_pos = i_start + IDX_W'(i);
            if (i_vec[w_pos]) begin
                o_idx   = w_pos;
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/priority_encoder_16to4.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_16to4
// Description : Sticky 16-bit request accumulator that issues one encoded
//               index per valid/ready handshake (fixed or round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_16to4
    import priority_encoder_16to4_pkg::*;
#(
    parameter int RR = POL_FIXED
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [ENC_W-1:0] REQ_IN,
    input  logic             ENC_READY,
    output logic [IDX_W-1:0] ENC_OUT,
    output logic             ENC_VALID,
    output logic [ENC_W-1:0] PEND_OUT,
    output logic [IDX_W:0]   PEND_CNT
);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [ENC_W-1:0] r_pend;
    logic [ENC_W-1:0] w_pend_nxt;
    logic [IDX_W-1:0] r_out;
    logic [IDX_W-1:0] w_out_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic [IDX_W:0]   r_cnt;

    logic [ENC_W-1:0] w_peff;
    logic             w_load;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    assign w_peff  = r_pend | REQ_IN;
    assign w_load  = (r_state == ST_IDLE) || ENC_READY;
    assign w_start = (RR == POL_RR) ? r_last + IDX_W'(1) : '0;

    priority_pick_16 u_pick (
        .i_vec   (w_peff),
        .i_start (w_start),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = w_peff;
        w_out_nxt   = r_out;
        w_last_nxt  = r_last;
        if (w_load) begin
            if (w_found) begin
                w_state_nxt = ST_PRESENT;
                w_out_nxt   = w_idx;
                w_last_nxt  = w_idx;
                w_pend_nxt  = w_peff & ~(ENC_W'(1) << w_idx);
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Count is taken from the next pending value so it tracks PEND_OUT exactly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_out   <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_out   <= w_out_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= popcount(w_pend_nxt);
        end
    end

    assign ENC_OUT   = r_out;
    assign ENC_VALID = (r_state == ST_PRESENT);
    assign PEND_OUT  = r_pend;
    assign PEND_CNT  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_16to4.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_16to4
// Description : Self-checking bench for the fixed and round-robin encoders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_16to4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        ready = 1'b0;

    logic [3:0]  f_out, r_out;
    logic        f_valid, r_valid;
    logic [15:0] f_pend, r_pend;
    logic [4:0]  f_cnt, r_cnt;

    int checks = 0;
    int failures = 0;
    logic [3:0] sb[$];

    typedef struct {
        logic [15:0] req;
        logic [3:0]  exp_out;
        logic [15:0] exp_pend;
        logic [4:0]  exp_cnt;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    priority_encoder_16to4 #(.RR(0)) u_fixed (
        .CLK(clk), .RST(rst), .REQ_IN(req), .ENC_READY(ready),
        .ENC_OUT(f_out), .ENC_VALID(f_valid), .PEND_OUT(f_pend), .PEND_CNT(f_cnt)
    );

    priority_encoder_16to4 #(.RR(1)) u_rr (
        .CLK(clk), .RST(rst), .REQ_IN(req), .ENC_READY(ready),
        .ENC_OUT(r_out), .ENC_VALID(r_valid), .PEND_OUT(r_pend), .PEND_CNT(r_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // Fixed policy with no new arrivals issues set bits in ascending order.
    task automatic push_ascending(input logic [15:0] v);
        for (int i = 0; i < 16; i++)
            if (v[i]) sb.push_back(4'(i));
    endtask

    task automatic drain_fixed(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || f_valid) && n < budget) begin
            if (f_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_extra: got index %0d expected none", name, f_out);
                end else begin
                    chk({name, "_idx"}, {28'b0, f_out}, {28'b0, sb.pop_front()});
                end
            end
            step();
            n++;
        end
        chk({name, "_done"}, {31'b0, (sb.size() == 0 && !f_valid)}, 32'd1);
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{16'h0001, 4'd0,  16'h0000, 5'd0};
        vecs[1] = '{16'h8010, 4'd4,  16'h8000, 5'd1};
        vecs[2] = '{16'hFFFF, 4'd0,  16'hFFFE, 5'd15};
        vecs[3] = '{16'h0100, 4'd8,  16'h0000, 5'd0};
        vecs[4] = '{16'hA000, 4'd13, 16'h8000, 5'd1};

        // Reset with all requests asserted: everything discarded.
        req = 16'hFFFF;
        do_reset(2);
        req = '0;
        chk("rst_valid", {31'b0, f_valid}, 0);
        chk("rst_out",   {28'b0, f_out},   0);
        chk("rst_pend",  {16'b0, f_pend},  0);
        chk("rst_cnt",   {27'b0, f_cnt},   0);
        step();
        chk("rst_after_valid", {31'b0, f_valid}, 0);
        chk("rst_after_pend",  {16'b0, f_pend},  0);

        // Table-driven one-shot requests, fixed policy, continuous ready.
        ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            req = vecs[t].req;
            push_ascending(vecs[t].req);
            step();
            req = '0;
            chk($sformatf("vec%0d_valid", t), {31'b0, f_valid}, 1);
            chk($sformatf("vec%0d_out", t),   {28'b0, f_out},   {28'b0, vecs[t].exp_out});
            chk($sformatf("vec%0d_pend", t),  {16'b0, f_pend},  {16'b0, vecs[t].exp_pend});
            chk($sformatf("vec%0d_cnt", t),   {27'b0, f_cnt},   {27'b0, vecs[t].exp_cnt});
            drain_fixed($sformatf("vec%0d", t), 40);
            chk($sformatf("vec%0d_pend_empty", t), {16'b0, f_pend}, 0);
        end

        // Backpressure: index 1 held for 5 cycles, bit 2 kept pending.
        ready = 1'b0;
        req = 16'h0006;
        step();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold%0d_out", c),   {28'b0, f_out},   1);
            chk($sformatf("bp_hold%0d_valid", c), {31'b0, f_valid}, 1);
            chk($sformatf("bp_hold%0d_pend", c),  {16'b0, f_pend},  16'h0004);
            chk($sformatf("bp_hold%0d_cnt", c),   {27'b0, f_cnt},   1);
            if (c < 4) step();
        end
        ready = 1'b1;
        step();
        chk("bp_next_out",   {28'b0, f_out},   2);
        chk("bp_next_valid", {31'b0, f_valid}, 1);
        chk("bp_next_pend",  {16'b0, f_pend},  0);
        step();
        chk("bp_end_valid", {31'b0, f_valid}, 0);

        // Re-request of the presented index while stalled, then full vector.
        ready = 1'b0;
        req = 16'h0001;
        step();
        chk("rereq_first_out", {28'b0, f_out}, 0);
        chk("rereq_first_pend", {16'b0, f_pend}, 0);
        step();
        req = '0;
        chk("rereq_pend", {16'b0, f_pend}, 16'h0001);
        chk("rereq_cnt",  {27'b0, f_cnt},  1);
        ready = 1'b1;
        step();
        chk("rereq_again_out",   {28'b0, f_out},   0);
        chk("rereq_again_valid", {31'b0, f_valid}, 1);
        chk("rereq_again_pend",  {16'b0, f_pend},  0);
        step();
        chk("rereq_end_valid", {31'b0, f_valid}, 0);

        ready = 1'b0;
        req = 16'h0001;
        step();
        req = 16'hFFFF;
        step();
        req = '0;
        chk("full_pend", {16'b0, f_pend}, 16'hFFFF);
        chk("full_cnt",  {27'b0, f_cnt},  16);

        // Mid-operation reset: pending 4..7 and presented 3 must vanish.
        do_reset(1);
        req = 16'h00F8;
        step();
        req = '0;
        chk("mid_pre_out",   {28'b0, f_out},   3);
        chk("mid_pre_valid", {31'b0, f_valid}, 1);
        chk("mid_pre_pend",  {16'b0, f_pend},  16'h00F0);
        do_reset(1);
        chk("mid_rst_valid", {31'b0, f_valid}, 0);
        chk("mid_rst_out",   {28'b0, f_out},   0);
        chk("mid_rst_pend",  {16'b0, f_pend},  0);
        chk("mid_rst_cnt",   {27'b0, f_cnt},   0);
        ready = 1'b1;
        req = 16'h0200;
        sb.push_back(4'd9);
        step();
        req = '0;
        drain_fixed("mid_after", 20);

        // Round-robin wrap with every bit held and continuous ready.
        do_reset(1);
        chk("rr_rst_valid", {31'b0, r_valid}, 0);
        req = 16'hFFFF;
        ready = 1'b1;
        for (int i = 0; i < 18; i++) sb.push_back(4'(i % 16));
        for (int i = 0; i < 18; i++) begin
            step();
            chk($sformatf("rr_valid%0d", i), {31'b0, r_valid}, 1);
            chk($sformatf("rr_idx%0d", i), {28'b0, r_out}, {28'b0, sb.pop_front()});
        end
        req = '0;
        do_reset(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
